action_wb_arbiter: RTL and testbench
====================================

// Module: action_wb_arbiter
// PURPOSE
//  Sits directly upstream of the register file write port. Merges pipeline writeback and per-thread action updates.
//  Pipeline writes always pass straight through. Action updates are buffered in a FIFO and drained only on idle cycles.
//  An action update is therefore never lost when it collides with a pipeline write.
// PARAMETERS
//  DATAPATH_WIDTH      64  pipeline writeback data width
//  REGFILE_ADDR_WIDTH  5   register address width
//  NUM_ACTIONS         4   action word width
//  THREAD_BITS         2   thread id width
//  ACT_FIFO_DEPTH      4   action FIFO entries; power of 2, >=2
//  STARVE_LIMIT        8   blocked-cycle threshold for the stall request (optional feature only)
// PORTS
//  clk               in   1                   clock, all state on posedge
//  reset             in   1                   synchronous, active-high
//  wb_wen            in   1                   pipeline writeback request
//  wb_addr           in   REGFILE_ADDR_WIDTH  pipeline write address
//  wb_data           in   DATAPATH_WIDTH      pipeline write data
//  act_valid         in   1                   action producer has an update
//  act_ready         out  1                   FIFO can accept an update
//  act_data          in   NUM_ACTIONS         action word
//  act_thread        in   THREAD_BITS         target thread
//  rf_wena           out  1                   to regfile wena
//  rf_wr_addr        out  REGFILE_ADDR_WIDTH  to regfile WR_addr_in
//  rf_wr_data        out  DATAPATH_WIDTH      to regfile WR_data_in
//  rf_action_wen     out  1                   to regfile action_wen
//  rf_action_data    out  NUM_ACTIONS         to regfile action_data_in
//  rf_action_thread  out  THREAD_BITS         to regfile action_thread_id_in
//  act_count         out  clog2(DEPTH)+1      current FIFO occupancy
//  wb_stall          out  1                   request upstream to skip one writeback (optional feature)
// BEHAVIOUR
//  - Reset: FIFO flushed, act_count=0, act_ready=1, rf_action_wen=0, wb_stall=0.
//    Reset mid-drain drops all queued entries.
//  - Pipeline path is combinational, zero latency: rf_wena=wb_wen, rf_wr_addr=wb_addr, rf_wr_data=wb_data.
//  - Push: act_valid && act_ready. act_ready = (act_count != DEPTH), registered from count.
//    A full FIFO does not accept, even when a pop happens in the same cycle.
//  - Pop: rf_action_wen = (act_count != 0) && !wb_wen.
//    rf_action_data and rf_action_thread show the head entry; the head advances on that edge.
//  - Priority: wb_wen is never delayed. An action is held in the FIFO while wb_wen=1.
//    At most one regfile write of either kind occurs per cycle.
//  - No bypass: an accepted action reaches rf_action_wen at the earliest 1 cycle after acceptance.
//  - Simultaneous push and pop: occupancy unchanged and order preserved (strict FIFO, no reordering across threads).
//  - Pointers wrap modulo DEPTH. act_count saturates neither way: an illegal push at full or pop at empty is impossible by construction.
//  - rf_action_data and rf_action_thread are don't-care while rf_action_wen=0. They are driven 0 after reset.
// CONFIGURATION
//  - ACTION_STARVE_GUARD_EN defined:
//    - starve_cnt counts cycles with act_count!=0 && wb_wen=1.
//    - starve_cnt clears on any pop, when the FIFO is empty, or on reset.
//    - When starve_cnt reaches STARVE_LIMIT, wb_stall is registered high the next cycle.
//    - wb_stall stays high until the cycle after the next pop.
//    - wb_wen asserted despite wb_stall still wins; the counter holds.
//  - Not defined: wb_stall tied 0, no counter; actions may wait indefinitely under continuous writeback.
// STRUCTURE
//  - Shared package arya_defs: DATAPATH_WIDTH, REGFILE_ADDR_WIDTH, NUM_ACTIONS, THREAD_BITS defaults.
//  - arya_defs also holds the per-thread action register map (thread n -> reg 8n+7).
//  - One sub-module: action_fifo (sync FIFO: push, pop, full, empty, count). Arbitration and starve logic stay in the top.
// TESTING
//  - Reset: assert reset 2 cycles with 3 entries queued -> act_count=0, act_ready=1, rf_action_wen=0 the cycle after.
//  - Idle drain: push thread 2 data 4'hA with wb_wen=0 -> next cycle rf_action_wen=1, thread=2, data=4'hA, act_count 1->0.
//  - Collision: push thread 1 data 4'h5, hold wb_wen=1 addr 3 for 3 cycles -> rf_wena passes all 3 and rf_action_wen=0.
//    After wb_wen drops, action pops the same cycle.
//  - Full: push 5 entries back-to-back with wb_wen=1 -> 4 accepted, act_ready=0 on 5th.
//    Release wb_wen -> entries emerge in push order, one per cycle.
//  - Push+pop same cycle at count 2 with wb_wen=0 -> count stays 2, order preserved.
//  - With ACTION_STARVE_GUARD_EN, STARVE_LIMIT=8, 1 entry queued, wb_wen held high -> wb_stall rises on the 9th cycle.
//    Drop wb_wen -> pop, then wb_stall=0 the next cycle.

Source files
------------

// File: rtl/arya_defs.sv
// +-----------------------------------------------------------------------+
// | Package     : arya_defs                                               |
// | Description : Shared datapath defaults and per-thread action register |
// |               map (thread n -> register 8n+7).                        |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package arya_defs;

    localparam int ARYA_DATAPATH_WIDTH     = 64;
    localparam int ARYA_REGFILE_ADDR_WIDTH = 5;
    localparam int ARYA_NUM_ACTIONS        = 4;
    localparam int ARYA_THREAD_BITS        = 2;

    // Thread n owns register 8n+7: the thread id lands in the upper bits, 3'b111 below.
    function automatic logic [ARYA_REGFILE_ADDR_WIDTH-1:0] action_reg_addr(
        input logic [ARYA_THREAD_BITS-1:0] thread
    );
        return {thread, 3'b111};
    endfunction

endpackage

`default_nettype wire

// File: rtl/action_fifo.sv
// +-----------------------------------------------------------------------+
// | Module      : action_fifo                                             |
// | Description : Synchronous FIFO with head-of-queue read, occupancy     |
// |               count, full and empty flags.                            |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

module action_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/action_wb_arbiter.sv
// +-----------------------------------------------------------------------+
// | Module      : action_wb_arbiter                                       |
// | Description : Merges pipeline writeback with queued per-thread action |
// |               updates; actions drain only on writeback-idle cycles.   |
// |               Optional starvation guard: ACTION_STARVE_GUARD_EN.      |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

module action_wb_arbiter
    import arya_defs::*;
#(
    parameter int DATAPATH_WIDTH     = ARYA_DATAPATH_WIDTH,
    parameter int REGFILE_ADDR_WIDTH = ARYA_REGFILE_ADDR_WIDTH,
    parameter int NUM_ACTIONS        = ARYA_NUM_ACTIONS,
    parameter int THREAD_BITS        = ARYA_THREAD_BITS,
    parameter int ACT_FIFO_DEPTH     = 4
`ifdef ACTION_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT       = 8
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wb_wen,
    input  logic [REGFILE_ADDR_WIDTH-1:0]     wb_addr,
    input  logic [DATAPATH_WIDTH-1:0]         wb_data,
    input  logic                              act_valid,
    output logic                              act_ready,
    input  logic [NUM_ACTIONS-1:0]            act_data,
    input  logic [THREAD_BITS-1:0]            act_thread,
    output logic                              rf_wena,
    output logic [REGFILE_ADDR_WIDTH-1:0]     rf_wr_addr,
    output logic [DATAPATH_WIDTH-1:0]         rf_wr_data,
    output logic                              rf_action_wen,
    output logic [NUM_ACTIONS-1:0]            rf_action_data,
    output logic [THREAD_BITS-1:0]            rf_action_thread,
    output logic [$clog2(ACT_FIFO_DEPTH):0]   act_count,
    output logic                              wb_stall
);

    localparam int EW = THREAD_BITS + NUM_ACTIONS;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [EW-1:0] w_head;

    assign rf_wena    = wb_wen;
    assign rf_wr_addr = wb_addr;
    assign rf_wr_data = wb_data;

    // Full blocks acceptance even if a pop frees a slot this cycle.
    assign act_ready = !w_full;
    assign w_push    = act_valid && act_ready;
    assign w_pop     = !w_empty && !wb_wen;

    action_fifo #(
        .WIDTH (EW),
        .DEPTH (ACT_FIFO_DEPTH)
    ) u_action_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata ({act_thread, act_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (act_count)
    );

    assign rf_action_wen    = w_pop;
    assign rf_action_thread = w_head[EW-1 -: THREAD_BITS];
    assign rf_action_data   = w_head[NUM_ACTIONS-1:0];

`ifdef ACTION_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic           w_blocked;
    logic [SCW-1:0] r_starve_cnt;
    logic           r_wb_stall;

    assign w_blocked = !w_empty && wb_wen;

    // Stall rises on the edge the counter reaches the limit and holds until a pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_wb_stall   <= 1'b0;
        end else begin
            if (w_pop || w_empty) begin
                r_starve_cnt <= '0;
            end else if (w_blocked && (r_starve_cnt != SCW'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (w_pop) begin
                r_wb_stall <= 1'b0;
            end else if (w_blocked && (r_starve_cnt >= SCW'(STARVE_LIMIT - 1))) begin
                r_wb_stall <= 1'b1;
            end
        end
    end

    assign wb_stall = r_wb_stall;
`else
    assign wb_stall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_action_wb_arbiter.sv
// +-----------------------------------------------------------------------+
// | Module      : tb_action_wb_arbiter                                    |
// | Description : Directed-vector bench for action_wb_arbiter.            |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_action_wb_arbiter;

`ifdef ACTION_STARVE_GUARD_EN
    localparam logic c_stall_en = 1'b1;
`else
    localparam logic c_stall_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        act_valid;
    logic        act_ready;
    logic [3:0]  act_data;
    logic [1:0]  act_thread;
    logic        rf_wena;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic        rf_action_wen;
    logic [3:0]  rf_action_data;
    logic [1:0]  rf_action_thread;
    logic [2:0]  act_count;
    logic        wb_stall;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    action_wb_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .wb_wen           (wb_wen),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .act_valid        (act_valid),
        .act_ready        (act_ready),
        .act_data         (act_data),
        .act_thread       (act_thread),
        .rf_wena          (rf_wena),
        .rf_wr_addr       (rf_wr_addr),
        .rf_wr_data       (rf_wr_data),
        .rf_action_wen    (rf_action_wen),
        .rf_action_data   (rf_action_data),
        .rf_action_thread (rf_action_thread),
        .act_count        (act_count),
        .wb_stall         (wb_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
        act_valid = 1'b0; act_data = '0; act_thread = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_count", act_count, 0);
        check("rst_ready", act_ready, 1);
        check("rst_awen", rf_action_wen, 0);
        check("rst_adata", rf_action_data, 0);
        check("rst_athread", rf_action_thread, 0);
        check("rst_stall", wb_stall, 0);

        // Queue three entries under writeback, then reset mid-queue
        wb_wen = 1'b1; wb_addr = 5'd7; wb_data = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 3; i++) begin
            act_valid = 1'b1; act_data = 4'(i + 1); act_thread = 2'(i);
            #1;
            check("q_wena", rf_wena, 1);
            tick();
        end
        act_valid = 1'b0;
        #1;
        check("q_count3", act_count, 3);
        check("q_awen_blocked", rf_action_wen, 0);
        wb_wen = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst2_count", act_count, 0);
        check("rst2_ready", act_ready, 1);
        check("rst2_awen", rf_action_wen, 0);

        // Idle drain
        act_valid = 1'b1; act_data = 4'hA; act_thread = 2'd2;
        #1;
        check("idle_nobypass", rf_action_wen, 0);
        tick();
        act_valid = 1'b0;
        #1;
        check("idle_awen", rf_action_wen, 1);
        check("idle_thread", rf_action_thread, 2);
        check("idle_data", rf_action_data, 4'hA);
        check("idle_count1", act_count, 1);
        tick();
        #1;
        check("idle_count0", act_count, 0);
        check("idle_awen0", rf_action_wen, 0);

        // Collision with pipeline writeback
        act_valid = 1'b1; act_data = 4'h5; act_thread = 2'd1;
        wb_wen = 1'b1; wb_addr = 5'd3; wb_data = 64'hDEAD_BEEF_0000_0003;
        tick();
        act_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("col_wena", rf_wena, 1);
            check("col_addr", rf_wr_addr, 3);
            check("col_data", rf_wr_data, 64'hDEAD_BEEF_0000_0003);
            check("col_awen", rf_action_wen, 0);
            tick();
        end
        wb_wen = 1'b0;
        #1;
        check("col_wena0", rf_wena, 0);
        check("col_pop", rf_action_wen, 1);
        check("col_pdata", rf_action_data, 4'h5);
        check("col_pthread", rf_action_thread, 1);
        tick();
        #1;
        check("col_count0", act_count, 0);

        // Fill to full under writeback, fifth push refused
        wb_wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            act_valid = 1'b1; act_data = 4'(i + 1); act_thread = 2'(i % 4);
            #1;
            check("full_ready", act_ready, (i < 4) ? 1 : 0);
            tick();
        end
        act_valid = 1'b0;
        #1;
        check("full_count", act_count, 4);
        check("full_ready0", act_ready, 0);
        wb_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            act_valid = (i == 0); act_data = 4'hF; act_thread = 2'd3;
            #1;
            check("drain_awen", rf_action_wen, 1);
            check("drain_data", rf_action_data, 64'(i + 1));
            check("drain_thread", rf_action_thread, 64'(i));
            if (i == 0) check("full_pop_noaccept", act_ready, 0);
            tick();
            if (i == 0) check("full_pop_count3", act_count, 3);
        end
        act_valid = 1'b0;
        #1;
        check("drain_count0", act_count, 0);
        check("drain_awen0", rf_action_wen, 0);

        // Simultaneous push and pop at occupancy 2
        wb_wen = 1'b1;
        act_valid = 1'b1; act_data = 4'h6; act_thread = 2'd0;
        tick();
        act_data = 4'h7; act_thread = 2'd1;
        tick();
        wb_wen = 1'b0; act_data = 4'h8; act_thread = 2'd2;
        #1;
        check("pp_count2", act_count, 2);
        check("pp_head6", rf_action_data, 4'h6);
        tick();
        act_valid = 1'b0;
        #1;
        check("pp_count_hold", act_count, 2);
        check("pp_head7", rf_action_data, 4'h7);
        check("pp_thread1", rf_action_thread, 1);
        tick();
        #1;
        check("pp_head8", rf_action_data, 4'h8);
        check("pp_thread2", rf_action_thread, 2);
        check("pp_count1", act_count, 1);
        tick();
        #1;
        check("pp_count0", act_count, 0);

        // Starvation: one entry held behind continuous writeback
        wb_wen = 1'b1; wb_addr = 5'd9;
        act_valid = 1'b1; act_data = 4'hC; act_thread = 2'd3;
        tick();
        act_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check("starve_low", wb_stall, 0);
            tick();
        end
        #1;
        check("starve_c9", wb_stall, c_stall_en);
        check("starve_c9_wena", rf_wena, 1);
        tick();
        #1;
        check("starve_c10", wb_stall, c_stall_en);
        check("starve_c10_awen", rf_action_wen, 0);
        wb_wen = 1'b0;
        #1;
        check("starve_pop", rf_action_wen, 1);
        check("starve_pop_data", rf_action_data, 4'hC);
        check("starve_pop_stall", wb_stall, c_stall_en);
        tick();
        #1;
        check("starve_clear", wb_stall, 0);
        check("starve_count0", act_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
